// File: rtl/ssd_bus_serializer_if.sv
// Word-in / beat-out bus between the formatter, the serializer and the flash data lanes.
// Carries the handshake, the parallel width reorderings and the presented beat.
interface ssd_bus_serializer_if;
  logic [15:0] data_in_16;
  logic [15:0] data_in_8;
  logic [15:0] data_in_4;
  logic [15:0] data_in_2;
  logic [15:0] data_in_1;
  logic [2:0]  bus_mode;
  logic        in_valid;
  logic        in_ready;
  logic        bus_hold;
  logic [15:0] dq;
  logic        dq_valid;
  logic        dq_last;

  modport master (
    output data_in_16, data_in_8, data_in_4, data_in_2, data_in_1,
    output bus_mode, in_valid, bus_hold,
    input  in_ready, dq, dq_valid, dq_last
  );

  modport slave (
    input  data_in_16, data_in_8, data_in_4, data_in_2, data_in_1,
    input  bus_mode, in_valid, bus_hold,
    output in_ready, dq, dq_valid, dq_last
  );
endinterface

// File: rtl/ssd_bus_serializer.sv
// Shifts a latched 16-bit word MSB-first onto w lanes over 16/w beats; first beat the cycle after accept.
// One-word holding register gives zero-bubble streaming; in_ready = !holding_full, bus_hold freezes the beat.
module ssd_bus_serializer #(
  parameter int WORD_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  ssd_bus_serializer_if.slave   bus,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  err_mode
);

  // Width held as log2(beats): 0=x16 .. 4=x1.
  logic [15:0] s_dat, h_dat, sel_dat;
  logic [2:0]  s_mode, h_mode, sel_mode;
  logic [3:0]  beat, last_idx;
  logic        s_vld, h_full;
  logic        accept, advance, retire, shifter_free;
  logic [4:0]  shamt;

  always_comb begin
    sel_mode = 3'd0;
    sel_dat  = bus.data_in_16;
    case (bus.bus_mode)
      3'd1: begin sel_mode = 3'd1; sel_dat = bus.data_in_8; end
      3'd2: begin sel_mode = 3'd2; sel_dat = bus.data_in_4; end
      3'd3: begin sel_mode = 3'd3; sel_dat = bus.data_in_2; end
      3'd4: begin sel_mode = 3'd4; sel_dat = bus.data_in_1; end
      default: ;
    endcase
  end

  always_comb begin
    last_idx = 4'd15;
    bus.dq   = 16'd0;
    case (s_mode)
      3'd0: begin last_idx = 4'd0; bus.dq = s_dat; end
      3'd1: begin last_idx = 4'd1; bus.dq = {8'd0,  s_dat[15:8]};  end
      3'd2: begin last_idx = 4'd3; bus.dq = {12'd0, s_dat[15:12]}; end
      3'd3: begin last_idx = 4'd7; bus.dq = {14'd0, s_dat[15:14]}; end
      default: begin last_idx = 4'd15; bus.dq = {15'd0, s_dat[15]}; end
    endcase
    if (!s_vld) bus.dq = 16'd0;
  end

  assign shamt        = 5'd16 >> s_mode;
  assign bus.in_ready = !h_full;
  assign bus.dq_valid = s_vld;
  assign bus.dq_last  = s_vld && (beat == last_idx);
  assign accept       = bus.in_valid && !h_full;
  assign advance      = s_vld && !bus.bus_hold;
  assign retire       = advance && bus.dq_last;
  assign shifter_free = !s_vld || retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dat    <= 16'd0;
      s_mode   <= 3'd0;
      s_vld    <= 1'b0;
      beat     <= 4'd0;
      h_dat    <= 16'd0;
      h_mode   <= 3'd0;
      h_full   <= 1'b0;
      word_cnt <= '0;
      err_mode <= 1'b0;
    end else if (flush) begin
      // Accept in this cycle is dropped along with everything in flight.
      s_dat    <= 16'd0;
      s_vld    <= 1'b0;
      beat     <= 4'd0;
      h_full   <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      err_mode <= accept && (bus.bus_mode > 3'd4);
      if (retire) word_cnt <= word_cnt + {{(WORD_CNT_W-1){1'b0}}, 1'b1};

      if (shifter_free) begin
        beat <= 4'd0;
        if (h_full) begin
          s_dat  <= h_dat;
          s_mode <= h_mode;
          s_vld  <= 1'b1;
          h_full <= accept;
          if (accept) begin
            h_dat  <= sel_dat;
            h_mode <= sel_mode;
          end
        end else if (accept) begin
          s_dat  <= sel_dat;
          s_mode <= sel_mode;
          s_vld  <= 1'b1;
        end else begin
          s_dat <= 16'd0;
          s_vld <= 1'b0;
        end
      end else begin
        if (advance) begin
          s_dat <= s_dat << shamt;
          beat  <= beat + 4'd1;
        end
        if (accept) begin
          h_dat  <= sel_dat;
          h_mode <= sel_mode;
          h_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_bus_serializer.sv
// Self-checking bench: queue-of-words reference model compared every cycle, plus directed literal scenarios.
module tb_ssd_bus_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_cnt;
  logic        err_mode;

  ssd_bus_serializer_if bus();

  ssd_bus_serializer #(.WORD_CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .word_cnt (word_cnt),
    .err_mode (err_mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: words in flight (oldest is on the bus) and the beat index of the oldest.
  logic [15:0] m_dat[$];
  int          m_mode[$];
  int          m_beat = 0;
  int          m_cnt = 0;
  bit          m_err = 0;

  always @(posedge clk) begin
    bit acc;
    int sm;
    logic [15:0] sd;
    if (!rst_n) begin
      m_dat.delete(); m_mode.delete();
      m_beat = 0; m_cnt = 0; m_err = 0;
    end else if (flush) begin
      m_dat.delete(); m_mode.delete();
      m_beat = 0; m_err = 0;
    end else begin
      acc   = bus.in_valid && (m_dat.size() < 2);
      m_err = acc && (bus.bus_mode > 3'd4);
      if (m_dat.size() > 0 && !bus.bus_hold) begin
        m_beat++;
        if (m_beat == (1 << m_mode[0])) begin
          void'(m_dat.pop_front());
          void'(m_mode.pop_front());
          m_beat = 0;
          m_cnt++;
        end
      end
      if (acc) begin
        case (bus.bus_mode)
          3'd1: begin sm = 1; sd = bus.data_in_8; end
          3'd2: begin sm = 2; sd = bus.data_in_4; end
          3'd3: begin sm = 3; sd = bus.data_in_2; end
          3'd4: begin sm = 4; sd = bus.data_in_1; end
          default: begin sm = 0; sd = bus.data_in_16; end
        endcase
        m_dat.push_back(sd);
        m_mode.push_back(sm);
      end
    end
  end

  // Expected-beat capture and DUT observation used by the directed checks.
  logic [16:0] cap[$];
  int run_len = 0, max_run = 0, err_seen = 0;
  bit nr_seen = 0;

  always @(negedge clk) begin
    int w, e_dq;
    bit e_vld, e_last;
    e_dq = 0; e_vld = 0; e_last = 0;
    if (m_dat.size() > 0) begin
      w      = 16 >> m_mode[0];
      e_dq   = (int'(m_dat[0]) >> (16 - w * (m_beat + 1))) & ((1 << w) - 1);
      e_vld  = 1;
      e_last = (m_beat == (16 / w) - 1);
    end
    chk("dq",       bus.dq,       e_dq);
    chk("dq_valid", bus.dq_valid, e_vld);
    chk("dq_last",  bus.dq_last,  e_last);
    chk("in_ready", bus.in_ready, (m_dat.size() < 2));
    chk("word_cnt", word_cnt,     m_cnt & 16'hFFFF);
    chk("err_mode", err_mode,     m_err);
    if (e_vld) cap.push_back({e_last, e_dq[15:0]});
    run_len = bus.dq_valid ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    if (!bus.in_ready) nr_seen = 1;
    if (err_mode) err_seen++;
  end

  task automatic drive_word(input int m, input logic [15:0] w);
    bus.data_in_16 = 16'($urandom);
    bus.data_in_8  = 16'($urandom);
    bus.data_in_4  = 16'($urandom);
    bus.data_in_2  = 16'($urandom);
    bus.data_in_1  = 16'($urandom);
    bus.bus_mode   = 3'(m);
    case (m)
      1: bus.data_in_8 = w;
      2: bus.data_in_4 = w;
      3: bus.data_in_2 = w;
      4: bus.data_in_1 = w;
      default: bus.data_in_16 = w;
    endcase
  endtask

  // Starts at a falling edge, returns at the falling edge after the accepting edge.
  task automatic send(input int m, input logic [15:0] w);
    int n = 0;
    #1;
    drive_word(m, w);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [15:0] cnt_before;
    bus.in_valid = 1'b0;
    bus.bus_hold = 1'b0;
    drive_word(0, 16'h0);

    cyc(2);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_dq_valid", bus.dq_valid, 0);
    chk("reset_word_cnt", word_cnt, 0);
    #1 rst_n = 1'b1;
    cyc(1);

    // x4 single word
    cap.delete();
    send(2, 16'hA5C3);
    #1 bus.in_valid = 1'b0;
    cyc(6);
    chk("x4_beats", cap.size(), 4);
    chk("x4_b0", cap[0], 17'h0000A);
    chk("x4_b1", cap[1], 17'h00005);
    chk("x4_b2", cap[2], 17'h0000C);
    chk("x4_b3", cap[3], 17'h10003);
    chk("x4_word_cnt", word_cnt, 1);

    // x1 back-to-back
    cap.delete(); nr_seen = 0; max_run = 0;
    send(4, 16'h8001);
    send(4, 16'hFFFF);
    #1 bus.in_valid = 1'b0;
    cyc(36);
    chk("x1_beats", cap.size(), 32);
    v = 32'h8001FFFF;
    for (int i = 0; i < 32; i++) begin
      chk("x1_bit", cap[i][0], v[31-i]);
      chk("x1_last", cap[i][16], (i == 15 || i == 31));
    end
    chk("x1_run", max_run, 32);
    chk("x1_not_ready_seen", nr_seen, 1);

    // hold during beat 0 with a second word filling H
    cap.delete();
    send(1, 16'h1234);
    #1 bus.bus_hold = 1'b1;
    drive_word(1, 16'h5678);
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1 bus.in_valid = 1'b0;
    chk("hold_in_ready", bus.in_ready, 0);
    cyc(2);
    #1 bus.bus_hold = 1'b0;
    cyc(8);
    chk("hold_beats", cap.size(), 7);
    for (int i = 0; i < 4; i++) chk("hold_b0", cap[i], 17'h00012);
    chk("hold_b1", cap[4], 17'h10034);
    chk("hold_w2b0", cap[5], 17'h00056);
    chk("hold_w2b1", cap[6], 17'h10078);

    // mode change then invalid mode
    cap.delete(); err_seen = 0;
    send(0, 16'hBEEF);
    send(7, 16'h0F0F);
    #1 bus.in_valid = 1'b0;
    cyc(4);
    chk("mode_beats", cap.size(), 2);
    chk("mode_w0", cap[0], 17'h1BEEF);
    chk("mode_w1", cap[1], 17'h10F0F);
    chk("mode_err_pulses", err_seen, 1);

    // flush on beat 2 of x2 with H full
    send(3, 16'hC3A5);
    send(3, 16'h1111);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    cnt_before = word_cnt;
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    chk("flush_dq_valid", bus.dq_valid, 0);
    chk("flush_word_cnt", word_cnt, cnt_before);
    chk("flush_in_ready", bus.in_ready, 1);
    // flush discards a same-cycle accept
    @(negedge clk);
    #1 flush = 1'b1;
    drive_word(0, 16'h4242);
    bus.in_valid = 1'b1;
    chk("flush_acc_in_ready", bus.in_ready, 1);
    @(negedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_acc_dropped", bus.dq_valid, 0);
    cyc(1);

    // async reset mid-word, then accept on first edge after release
    send(4, 16'hAAAA);
    #1 bus.in_valid = 1'b0;
    cyc(3);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_dq_valid", bus.dq_valid, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;
    send(0, 16'h1357);
    #1 bus.in_valid = 1'b0;
    cyc(2);
    chk("post_rst_word_cnt", word_cnt, 1);

    // randomized traffic
    repeat (600) begin
      @(negedge clk);
      #1;
      drive_word($urandom_range(0, 7), 16'($urandom));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.bus_hold = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.bus_hold = 1'b0;
    flush        = 1'b0;
    cyc(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
